alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: ILLEGAL_RESULT, 32'h0000_0000, the result value returned for an undefined operation code.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid_i[k]  input  1 each (k=0,1)  requester k presents an operation.
REQ-005 req_data_i[k]  input  alu_data_t (68) each  operands a, b (signed 32) and the 4-bit code.
REQ-006 req_ready_o[k]  output  1 each  the operation from requester k is accepted this cycle.
REQ-007 rsp_valid_o[k]  output  1 each  a result for requester k is available.
REQ-008 rsp_ready_i[k]  input  1 each  requester k consumes its result.
REQ-009 rsp_result_o  output  32  the result; shared by both ports and meaningful only while some rsp_valid_o[k] is high.
REQ-010 rsp_err_o  output  1  the held result came from an undefined code.
REQ-011 busy_o  output  1  a result is held and not yet consumed.

Function
REQ-012 The block has a 2-state FSM:
- IDLE: no result is held.
- RESP: one result is held for the owner port.
REQ-013 A port is "open" in these cases:
- the FSM is in IDLE;
- the FSM is in RESP and the owner's rsp_valid/rsp_ready handshake completes in the same cycle.
REQ-014 When the port is open and at least one req_valid_i is high, exactly one requester is granted.
- req_ready_o is high only for the granted requester, and is derived combinationally in that cycle.
- All other req_ready_o stay low.
REQ-015 On a grant, the block computes the operation combinationally and registers the result, the error flag and the owner index. The FSM goes to (or stays in) RESP.
- rsp_valid_o[owner] goes high on the next cycle, giving a latency of 1.
- Throughput is one operation per cycle when rsp_ready is held high.
REQ-016 If the owner handshake completes with no new grant, the FSM goes RESP -> IDLE and all rsp_valid_o go low on the next cycle.
REQ-017 While in RESP without a handshake:
- rsp_result_o, rsp_err_o and the owner are held stable;
- all req_ready_o are low.
REQ-018 Operations:
- ADD and SUB: modulo 2^32, with no overflow flag.
- SLL, SRL, SRA: shift amount is b[4:0]; SRA sign-extends.
- SLT: signed compare; SLTU: unsigned compare; each returns 32'd1 or 32'd0.
- XOR, OR, AND: bitwise.
REQ-019 Undefined codes (0110 and 1011-1111) return ILLEGAL_RESULT with rsp_err_o=1; all defined codes return rsp_err_o=0.
REQ-020 rsp_valid_o is never high for both ports at once.
REQ-021 When only one req_valid_i is high, that requester is granted, independent of the priority state.
REQ-022 A requester's req_data_i is not required to be stable after its acceptance cycle.

Reset
REQ-023 When rst is asserted, the block immediately, without waiting for clk:
- enters IDLE;
- drives rsp_valid_o=0, rsp_result_o=0, rsp_err_o=0, busy_o=0;
- sets the priority pointer to requester 0.
REQ-024 Reset while a result is held, whether in RESP or during a handshake, discards that result; it is never delivered afterward.
REQ-025 While rst is high, all req_ready_o are 0.
REQ-026 The first grant after rst deasserts follows the normal rules.

Configuration
REQ-027 Macro ALU_ARB_ROUND_ROBIN_EN.
- Defined: on a simultaneous request, the requester not granted last wins.
- Defined: the pointer toggles only on an actual grant and starts at 0 after reset.
REQ-028 Not defined: requester 0 always wins a simultaneous request (fixed priority). All other behaviour is identical.

Verification
REQ-029 Port0 ADD a=5, b=-7, both rsp_ready high -> req_ready_o[0]=1 in the same cycle; next cycle rsp_valid_o[0]=1, rsp_result_o=32'hFFFFFFFE, rsp_err_o=0.
REQ-030 Both ports valid every cycle (port0 SUB 10-3, port1 AND F0F0&FF00), with ROUND_ROBIN_EN defined -> grants alternate 0,1,0,1 with results 7, 32'h0000F000. Undefined -> port0 always granted and port1 starves.
REQ-031 Port0 SRA a=32'h80000000, b=32'h00000021, with rsp_ready_i[0] low for 3 cycles -> result 32'hC0000000 held stable, all req_ready_o low, busy_o high. It is delivered when ready rises.
REQ-032 SLT and SLTU with a=-1, b=1 -> 32'd1 and 32'd0 respectively.
REQ-033 Code 4'b1100 with ILLEGAL_RESULT=32'hDEADBEEF -> rsp_result_o=32'hDEADBEEF and rsp_err_o=1. The following ADD 1+1 gives 2 with rsp_err_o=0.
REQ-034 Assert rst mid-cycle while in RESP -> rsp_valid_o drops before the next clk edge. After release, a port1 OR 1|2 request returns 3 one cycle after acceptance.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester ALU with one result register, 1-cycle latency and a per-port valid/ready response.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
package alu_arbiter_pkg;
  typedef struct packed {
    logic signed [31:0] a;
    logic signed [31:0] b;
    logic [3:0]         op;
  } alu_data_t;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_SLL  = 4'b0010;
  localparam logic [3:0] OP_SLT  = 4'b0011;
  localparam logic [3:0] OP_SLTU = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_OR   = 4'b1001;
  localparam logic [3:0] OP_AND  = 4'b1010;
endpackage

module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter logic [31:0] ILLEGAL_RESULT = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid_i,
  input  alu_data_t   req_data_i [2],
  output logic [1:0]  req_ready_o,
  output logic [1:0]  rsp_valid_o,
  input  logic [1:0]  rsp_ready_i,
  output logic [31:0] rsp_result_o,
  output logic        rsp_err_o,
  output logic        busy_o
);

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  state_t      state_r, state_next_s;
  logic        owner_r;
  logic [1:0]  rsp_valid_r;
  logic [31:0] result_r;
  logic        err_r;
  logic        hs_s, open_s, gnt_s, gnt_idx_s;
  logic [32:0] alu_out_s;
`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic        prio_r;
`endif

  // Returns {err, result}; undefined codes yield ILLEGAL_RESULT with err set.
  function automatic logic [32:0] alu_exec(input alu_data_t d);
    logic [31:0] res;
    logic        err;
    res = 32'h0000_0000;
    err = 1'b0;
    case (d.op)
      OP_ADD:  res = d.a + d.b;
      OP_SUB:  res = d.a - d.b;
      OP_SLL:  res = d.a << d.b[4:0];
      OP_SRL:  res = $unsigned(d.a) >> d.b[4:0];
      OP_SRA:  res = $signed(d.a) >>> d.b[4:0];
      OP_SLT:  res = ($signed(d.a) < $signed(d.b)) ? 32'd1 : 32'd0;
      OP_SLTU: res = ($unsigned(d.a) < $unsigned(d.b)) ? 32'd1 : 32'd0;
      OP_XOR:  res = d.a ^ d.b;
      OP_OR:   res = d.a | d.b;
      OP_AND:  res = d.a & d.b;
      default: begin
        res = ILLEGAL_RESULT;
        err = 1'b1;
      end
    endcase
    return {err, res};
  endfunction

  // Port-open detection and grant selection
  always_comb begin
    hs_s   = (state_r == RESP) && rsp_ready_i[owner_r];
    open_s = (state_r == IDLE) || hs_s;
    gnt_s  = open_s && (|req_valid_i) && !rst;
    if (req_valid_i == 2'b11) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
      gnt_idx_s = prio_r;
`else
      gnt_idx_s = 1'b0;
`endif
    end else begin
      gnt_idx_s = req_valid_i[1];
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (gnt_s) state_next_s = RESP;
        else       state_next_s = IDLE;
      end
      RESP: begin
        if (gnt_s)     state_next_s = RESP;
        else if (hs_s) state_next_s = IDLE;
        else           state_next_s = RESP;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Output logic: one-hot accept strobe and the operation on the granted operands
  always_comb begin
    req_ready_o = 2'b00;
    alu_out_s   = alu_exec(req_data_i[gnt_idx_s]);
    if (gnt_s) begin
      req_ready_o = gnt_idx_s ? 2'b10 : 2'b01;
    end else begin
      req_ready_o = 2'b00;
    end
  end

  // Result register; a grant overrides the handshake so back-to-back issue sustains one per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_r     <= 1'b0;
      rsp_valid_r <= 2'b00;
      result_r    <= 32'h0000_0000;
      err_r       <= 1'b0;
    end else if (gnt_s) begin
      owner_r     <= gnt_idx_s;
      rsp_valid_r <= gnt_idx_s ? 2'b10 : 2'b01;
      result_r    <= alu_out_s[31:0];
      err_r       <= alu_out_s[32];
    end else if (hs_s) begin
      rsp_valid_r <= 2'b00;
    end
  end

`ifdef ALU_ARB_ROUND_ROBIN_EN
  // Priority pointer: the requester not granted last wins the next tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_r <= 1'b0;
    end else if (gnt_s) begin
      prio_r <= ~gnt_idx_s;
    end
  end
`endif

  assign rsp_valid_o  = rsp_valid_r;
  assign rsp_result_o = result_r;
  assign rsp_err_o    = err_r;
  assign busy_o       = (state_r == RESP);

endmodule
